// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux; optional retired counter via MEM_WB_RETIRE_CNT_EN.
// Latency: 1 cycle In* -> Out*; WbData/WbEn are combinational from the registered stage.
// Backpressure: Stall holds every register, Flush inserts a zeroed bubble and overrides Stall.
module mem_wb_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter bit ZERO_REG_HW = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic                  InRegWrite,
    input  logic                  InMemtoReg,
    input  logic [DATA_W-1:0]     InReadData,
    input  logic [DATA_W-1:0]     InAluResult,
    input  logic [REG_ADDR_W-1:0] InWriteReg,
    output logic                  OutValid,
    output logic                  OutRegWrite,
    output logic                  OutMemtoReg,
    output logic [DATA_W-1:0]     OutReadData,
    output logic [DATA_W-1:0]     OutAluResult,
    output logic [REG_ADDR_W-1:0] OutWriteReg,
    output logic [DATA_W-1:0]     WbData,
    output logic                  WbEn
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]      RetireCnt
`endif
);

    logic load;
    logic dest_ok;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign load = !Flush && !Stall;

    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            OutValid     <= 1'b0;
            OutRegWrite  <= 1'b0;
            OutMemtoReg  <= 1'b0;
            OutReadData  <= '0;
            OutAluResult <= '0;
            OutWriteReg  <= '0;
        end else if (load) begin
            OutValid     <= InValid;
            // Control bits are masked so they can never be set on a bubble.
            OutRegWrite  <= InRegWrite & InValid;
            OutMemtoReg  <= InMemtoReg & InValid;
            OutReadData  <= InReadData;
            OutAluResult <= InAluResult;
            OutWriteReg  <= InWriteReg;
        end
    end

    assign dest_ok = ZERO_REG_HW ? (OutWriteReg != '0) : 1'b1;
    assign WbEn    = OutValid & OutRegWrite & dest_ok;
    assign WbData  = OutMemtoReg ? OutReadData : OutAluResult;

`ifdef MEM_WB_RETIRE_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RetireCnt <= '0;
        end else if (load && InValid) begin
            RetireCnt <= RetireCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (ZERO_REG_HW=1 and =0 instances, CNT_W=4).
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        InValid = 1'b0;
    logic        InRegWrite = 1'b0;
    logic        InMemtoReg = 1'b0;
    logic [31:0] InReadData = '0;
    logic [31:0] InAluResult = '0;
    logic [4:0]  InWriteReg = '0;

    logic        OutValid, OutRegWrite, OutMemtoReg, WbEn;
    logic [31:0] OutReadData, OutAluResult, WbData;
    logic [4:0]  OutWriteReg;

    logic        z_OutValid, z_OutRegWrite, z_OutMemtoReg, z_WbEn;
    logic [31:0] z_OutReadData, z_OutAluResult, z_WbData;
    logic [4:0]  z_OutWriteReg;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [3:0]  RetireCnt, z_RetireCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_HW(1'b1), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .InRegWrite(InRegWrite), .InMemtoReg(InMemtoReg),
        .InReadData(InReadData), .InAluResult(InAluResult), .InWriteReg(InWriteReg),
        .OutValid(OutValid), .OutRegWrite(OutRegWrite), .OutMemtoReg(OutMemtoReg),
        .OutReadData(OutReadData), .OutAluResult(OutAluResult), .OutWriteReg(OutWriteReg),
        .WbData(WbData), .WbEn(WbEn)
`ifdef MEM_WB_RETIRE_CNT_EN
        , .RetireCnt(RetireCnt)
`endif
    );

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_HW(1'b0), .CNT_W(4)) dut_nz (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .InRegWrite(InRegWrite), .InMemtoReg(InMemtoReg),
        .InReadData(InReadData), .InAluResult(InAluResult), .InWriteReg(InWriteReg),
        .OutValid(z_OutValid), .OutRegWrite(z_OutRegWrite), .OutMemtoReg(z_OutMemtoReg),
        .OutReadData(z_OutReadData), .OutAluResult(z_OutAluResult), .OutWriteReg(z_OutWriteReg),
        .WbData(z_WbData), .WbEn(z_WbEn)
`ifdef MEM_WB_RETIRE_CNT_EN
        , .RetireCnt(z_RetireCnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
        InValid     = v;
        InRegWrite  = rw;
        InMemtoReg  = m2r;
        InReadData  = rd;
        InAluResult = alu;
        InWriteReg  = wr;
    endtask

    initial begin
        // Reset with a live instruction on the inputs: reset must still win.
        drive(1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'h6666_6666, 5'd9);
        step();
        step();
        chk("rst_valid",   {63'd0, OutValid},    64'd0);
        chk("rst_regwr",   {63'd0, OutRegWrite}, 64'd0);
        chk("rst_m2r",     {63'd0, OutMemtoReg}, 64'd0);
        chk("rst_rdata",   {32'd0, OutReadData}, 64'd0);
        chk("rst_alu",     {32'd0, OutAluResult}, 64'd0);
        chk("rst_wreg",    {59'd0, OutWriteReg}, 64'd0);
        chk("rst_wbdata",  {32'd0, WbData},      64'd0);
        chk("rst_wben",    {63'd0, WbEn},        64'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("rst_cnt",     {60'd0, RetireCnt},   64'd0);
`endif

        Reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0055, 32'h0000_00AA, 5'd5);
        step();
        chk("load_valid",  {63'd0, OutValid},    64'd1);
        chk("load_wbdata", {32'd0, WbData},      64'h0000_00AA);
        chk("load_wben",   {63'd0, WbEn},        64'd1);
        chk("load_wreg",   {59'd0, OutWriteReg}, 64'd5);

        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd6);
        step();
        chk("m2r_sel_rd",  {32'd0, WbData},      64'hDEAD_BEEF);
        chk("m2r_bit",     {63'd0, OutMemtoReg}, 64'd1);
        InMemtoReg = 1'b0;
        step();
        chk("m2r_sel_alu", {32'd0, WbData},      64'h0000_1234);

        drive(1'b1, 1'b1, 1'b1, 32'h0000_0011, 32'h0000_0099, 5'd3);
        step();
        chk("pre_stall",   {32'd0, WbData},      64'h11);
        Stall = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0022, 32'h0000_0088, 5'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", {32'd0, OutReadData}, 64'h11);
            chk("stall_wreg", {59'd0, OutWriteReg}, 64'd3);
            chk("stall_wben", {63'd0, WbEn},        64'd1);
        end
        Stall = 1'b0;
        step();
        chk("unstall_data", {32'd0, WbData},      64'h22);
        chk("unstall_wreg", {59'd0, OutWriteReg}, 64'd7);

        Flush = 1'b1;
        Stall = 1'b1;
        step();
        chk("flush_valid", {63'd0, OutValid},    64'd0);
        chk("flush_wben",  {63'd0, WbEn},        64'd0);
        chk("flush_wreg",  {59'd0, OutWriteReg}, 64'd0);
        chk("flush_rdata", {32'd0, OutReadData}, 64'd0);
        chk("flush_regwr", {63'd0, OutRegWrite}, 64'd0);
        Flush = 1'b0;
        Stall = 1'b0;

        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd0);
        step();
        chk("zero_reg_hw1", {63'd0, WbEn},    64'd0);
        chk("zero_reg_hw0", {63'd0, z_WbEn},  64'd1);
        chk("zero_reg_data", {32'd0, WbData}, 64'h77);

        drive(1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0033, 5'd4);
        step();
        chk("inv_regwr",  {63'd0, OutRegWrite}, 64'd0);
        chk("inv_m2r",    {63'd0, OutMemtoReg}, 64'd0);
        chk("inv_valid",  {63'd0, OutValid},    64'd0);
        chk("inv_wben",   {63'd0, z_WbEn},      64'd0);

        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0010, 5'd2);
        step();
        chk("pre_rst_wben", {63'd0, WbEn}, 64'd1);
        Stall = 1'b1;
        Reset = 1'b1;
        step();
        chk("rst_in_stall_valid", {63'd0, OutValid}, 64'd0);
        chk("rst_in_stall_wben",  {63'd0, WbEn},     64'd0);
        chk("rst_in_stall_alu",   {32'd0, OutAluResult}, 64'd0);
        Stall = 1'b0;
        Reset = 1'b0;

`ifdef MEM_WB_RETIRE_CNT_EN
        chk("cnt_after_rst", {60'd0, RetireCnt}, 64'd0);
        // Bubble load must not count.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd1);
        step();
        chk("cnt_bubble", {60'd0, RetireCnt}, 64'd0);
        // 25 cycles, valid inputs throughout: 3 stalls + 2 flushes -> 20 loads, 20 mod 16 = 4.
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, i, 5'd1);
            Stall = (i == 3 || i == 9 || i == 15);
            Flush = (i == 6 || i == 18);
            step();
        end
        Stall = 1'b0;
        Flush = 1'b0;
        chk("cnt_wrap", {60'd0, RetireCnt}, 64'd4);
        Reset = 1'b1;
        step();
        chk("cnt_mid_rst", {60'd0, RetireCnt}, 64'd0);
        Reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
